// File: rtl/palette_index_encoder.sv
// Nearest-colour encoder: maps a 24-bit RGB pixel to a 4-bit sprite palette index
// by scanning palette entries 1..15 one per cycle; entry 0 is reserved for transparency.
module palette_index_encoder #(
  parameter logic [23:0] TRANSPARENT_KEY = 24'h000000,
  parameter bit          EARLY_EXIT      = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [23:0] i_palette [16],
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  input  logic [23:0] i_pix_rgb,
  output logic        o_idx_valid,
  input  logic        i_idx_ready,
  output logic [3:0]  o_idx,
  output logic        o_exact,
  output logic [9:0]  o_dist,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: a pixel transfers on a rising edge where i_pix_valid && o_pix_ready;
  // a result transfers on a rising edge where o_idx_valid && i_idx_ready. A producer
  // holds its payload stable until the transfer; valid never depends on ready.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e      state_q;
  logic        pix_ready_q;
  logic        idx_valid_q;
  logic [3:0]  idx_q;
  logic        exact_q;
  logic [9:0]  dist_q;
  logic [23:0] pix_q;
  logic [3:0]  cand_q;
  logic [3:0]  best_idx_q;
  logic [9:0]  best_dist_q;

  logic [23:0] cand_rgb;
  logic [9:0]  cand_dist;
  logic        cand_better;
  logic        cand_last;
  logic [3:0]  best_idx_d;
  logic [9:0]  best_dist_d;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    if (a > b) r = a - b;
    else       r = b - a;
    return r;
  endfunction

  // Manhattan distance in RGB space; 3 x 255 fits in 10 bits.
  function automatic logic [9:0] rgb_dist(input logic [23:0] a, input logic [23:0] b);
    logic [9:0] dr;
    logic [9:0] dg;
    logic [9:0] db;
    dr = {2'b00, abs_diff(a[23:16], b[23:16])};
    dg = {2'b00, abs_diff(a[15:8],  b[15:8])};
    db = {2'b00, abs_diff(a[7:0],   b[7:0])};
    return dr + dg + db;
  endfunction

  always_comb begin
    cand_rgb    = i_palette[cand_q];
    cand_dist   = rgb_dist(pix_q, cand_rgb);
    // Strict compare keeps the lower index on ties.
    cand_better = (cand_dist < best_dist_q);
    best_idx_d  = best_idx_q;
    best_dist_d = best_dist_q;
    if (cand_better) begin
      best_idx_d  = cand_q;
      best_dist_d = cand_dist;
    end
    cand_last = (EARLY_EXIT && (cand_dist == 10'd0)) || (cand_q == 4'd15);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      pix_ready_q <= 1'b1;
      idx_valid_q <= 1'b0;
      idx_q       <= 4'd0;
      exact_q     <= 1'b0;
      dist_q      <= 10'd0;
      pix_q       <= 24'd0;
      cand_q      <= 4'd0;
      best_idx_q  <= 4'd0;
      best_dist_q <= 10'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_pix_valid) begin
            pix_q       <= i_pix_rgb;
            pix_ready_q <= 1'b0;
            if (i_pix_rgb == TRANSPARENT_KEY) begin
              idx_q       <= 4'd0;
              dist_q      <= 10'd0;
              exact_q     <= 1'b1;
              idx_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              cand_q      <= 4'd1;
              best_idx_q  <= 4'd1;
              best_dist_q <= 10'h3FF;
              state_q     <= S_SEARCH;
            end
          end
        end
        S_SEARCH: begin
          best_idx_q  <= best_idx_d;
          best_dist_q <= best_dist_d;
          if (cand_last) begin
            idx_q       <= best_idx_d;
            dist_q      <= best_dist_d;
            exact_q     <= (best_dist_d == 10'd0);
            idx_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cand_q <= cand_q + 4'd1;
          end
        end
        S_DONE: begin
          // No bypass to accept: ready only rises after the result leaves.
          if (i_idx_ready) begin
            idx_valid_q <= 1'b0;
            pix_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          idx_valid_q <= 1'b0;
          pix_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_pix_ready = pix_ready_q;
  assign o_idx_valid = idx_valid_q;
  assign o_idx       = idx_q;
  assign o_exact     = exact_q;
  assign o_dist      = dist_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/palette_index_encoder.md
Name: palette_index_encoder

Overview:
Reverse of the sprite palette lookup: converts a 24-bit RGB pixel into the 4-bit palette index that sprite ROM/RAM stores. Used by the asset-load path (UART/SD pixel stream → sprite memory) so art can be streamed as true-colour and stored indexed. Searches the supplied 16-entry palette sequentially, one entry per cycle, for the nearest colour. Index 0 is reserved for transparency.

Parameters:
TRANSPARENT_KEY, 24'h000000, RGB value that maps directly to index 0; entry 0 is never searched.
EARLY_EXIT, 1, 1 = stop the search on the first distance-0 entry; 0 = always scan entries 1..15.

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_palette  input  16x24  palette array [0:15], RGB888; must be stable from accept to output handshake
i_pix_valid  input  1  input pixel valid
o_pix_ready  output  1  encoder can accept a pixel
i_pix_rgb  input  24  pixel {R[23:16],G[15:8],B[7:0]}
o_idx_valid  output  1  result valid
i_idx_ready  input  1  downstream accepts result
o_idx  output  4  chosen palette index
o_exact  output  1  chosen entry distance is 0
o_dist  output  10  distance of the chosen entry

Behaviour:
- One clock i_clk; reset asynchronous, active-low on i_rst_n. All state flops reset asynchronously.
- Reset values: state=IDLE, o_pix_ready=1, o_idx_valid=0, o_idx=0, o_exact=0, o_dist=0, internal pixel/best registers 0.
- Distance = |dR|+|dG|+|dB|, each term 8-bit unsigned absolute difference, zero-extended, sum 10 bits (max 765, no overflow).
- FSM states IDLE, SEARCH, DONE. o_pix_ready = (state==IDLE). o_idx_valid = (state==DONE).
- IDLE: on i_pix_valid (accept cycle T), register pixel.
  - If pixel == TRANSPARENT_KEY: load idx=0, dist=0, exact=1, go to DONE (o_idx_valid at T+1).
  - Else: cand=1, best_dist=10'h3FF, best_idx=1, go to SEARCH.
- SEARCH: each cycle evaluate entry cand. Update best when dist < best_dist (strict), so ties keep the lower index.
  - If (EARLY_EXIT && dist==0) or cand==15: go to DONE with the updated best.
  - Else cand increments.
  - Entry k is evaluated at cycle T+k.
- Latency: full scan gives o_idx_valid at T+16; early exact hit at entry k gives T+k+1; transparent key gives T+1.
- DONE: o_idx/o_exact/o_dist hold stable while o_idx_valid=1 and i_idx_ready=0. On i_idx_ready=1, return to IDLE next cycle. o_pix_ready rises the cycle after the handshake.
  - Throughput: at most one pixel per (search+2) cycles. No bypass from DONE to accept.
- o_exact = (o_dist==0). A pixel equal to a colour only at entry 0 (≠ key) is not matched to index 0.
- i_pix_rgb and i_pix_valid are ignored outside IDLE. i_idx_ready is ignored outside DONE.
- Palette changes during SEARCH: result undefined (not checked); the loader must not change it.
- Reset asserted mid-SEARCH or DONE: immediate return to reset values; the in-flight pixel is dropped with no output.

Test Plan:
1. Bench palette {0:000000, 1:ffff00, 4:7efe00, 9:00ff00, 12:e24efd, others distinct}. Push e24efd, i_idx_ready=1 → o_idx_valid at T+13, o_idx=12, o_exact=1, o_dist=0. With EARLY_EXIT=0 → same result at T+16.
2. Push 00fe00 → full scan, o_idx_valid at T+16, o_idx=9, o_dist=1, o_exact=0 (entry 4 dist 126 rejected).
3. Push 000000 → o_idx_valid at T+1, o_idx=0, o_exact=1. Push 000001 → searched normally, never index 0.
4. Tie: entries 2=101010 and 3=303030, pixel 202020 (both dist 48, all others farther) → o_idx=2, o_dist=48.
5. Backpressure: hold i_idx_ready=0 for 5 cycles in DONE → outputs constant, o_pix_ready=0, new i_pix_valid ignored. Release → o_pix_ready=1 one cycle after the handshake.
6. Assert i_rst_n=0 at T+7 of a search → all outputs at reset values immediately. After release, a fresh pixel encodes correctly with no stale output.
